mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle sequencer for 32-bit unsigned multiplication. It sits beside the shared 32-bit ALU and drives that ALU's operation, A and B inputs. It computes the low 32 bits of a×b by shift-and-add, using only the ALU ADD, SLL and SRL operations, and one ALU operation per clock. It also stores a held product register for the datapath.

## Interface
- No parameters. Operand width is fixed at 32 bits; ALU operation codes are fixed: ADD=4'b0011, SLL=4'b0100, SRL=4'b0110.
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  request pulse; accepted only in IDLE
- a  in  32  multiplicand, sampled on the accepting edge
- b  in  32  multiplier, sampled on the accepting edge
- busy  out  1  high in ADD, SHL, SHR states
- done  out  1  high for exactly one cycle (DONE state)
- product  out  32  low 32 bits of a×b, held until next DONE
- alu_op  out  4  ALUOperation drive to the ALU
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_result  in  32  ALUResult returned by the ALU, combinational, same cycle

## Operation
- Internal registers:
  - acc[31:0]
  - mcand[31:0]
  - mplier[31:0]
  - iter[5:0] (iteration count, saturating at 32)
  - state
- States and transitions:
  - IDLE → ADD when start=1. On that edge: acc←0, mcand←a, mplier←b, iter←0.
  - ADD → SHL. Drive alu_op=ADD, alu_a=acc, alu_b = mplier[0] ? mcand : 0; acc←alu_result.
  - SHL → SHR. Drive alu_op=SLL, alu_a=mcand, alu_b=1; mcand←alu_result.
  - SHR → DONE if alu_result==0, otherwise → ADD. Drive alu_op=SRL, alu_a=mplier, alu_b=1; mplier←alu_result, iter←iter+1.
  - DONE → IDLE unconditionally. On entry to DONE: product←acc.
- Output drive in IDLE and DONE: alu_op=ADD, alu_a=0, alu_b=0.
- Arithmetic is modulo 2^32. Carries out of bit 31 and bits shifted out are discarded; there is no overflow flag.
- Iteration count n = max(1, index of the highest set bit of b + 1), so 1 ≤ n ≤ 32. The iteration counter must never exceed 32.
- Boundary conditions:
  - start while busy or in DONE: ignored, with no effect on operands or state.
  - start held high continuously: a new operation is accepted on each IDLE cycle.
  - b=0: one iteration, product=0.
  - a=0: normal iteration count, product=0.
  - reset at any time, including mid-operation: on that edge state←IDLE and acc, mcand, mplier, iter, product ← 0. The in-flight operation is discarded, and done is not asserted for it.
  - reset and start on the same edge: reset wins, and start is not accepted.
- Reset values:
  - busy=0
  - done=0
  - product=0
  - alu_op=4'b0011
  - alu_a=0
  - alu_b=0

## Timing
- Accepting edge E0: start=1 while in IDLE.
- ALU path: alu_op, alu_a and alu_b are decoded from registered state only. alu_result is captured on the same cycle's edge, giving one ALU operation per cycle and no pipelining.
- Each iteration is 3 cycles: ADD, SHL, SHR.
- done and busy timing:
  - done=1 during the cycle after edge E(3n) and low again after E(3n+1).
  - busy=1 from after E0 through after E(3n−1).
  - product is valid in the same cycle as done, and remains stable until the next DONE.
- Earliest next accept: edge E(3n+2), the first IDLE cycle. Accept-to-accept minimum is 3n+2 cycles.
- Maximum latency: n=32, so done appears 96 edges after E0.

## Test plan
- a=3, b=5 (n=3) → busy for 9 cycles; done one cycle after E9; product=15; alu_op sequence 0011,0100,0110 repeated 3×.
- a=7, b=0 → n=1; done after E3; product=0; the first ADD cycle drives alu_b=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF → n=32; done after E96; product=0x00000001.
- Ignored start and back-to-back: start pulsed during SHL of a 3×5 run → ignored; product=15. Then a new start (a=2, b=2) in the first IDLE cycle → product=4, with done after 6 more edges.
- reset asserted during the 2nd iteration of a=9, b=9 → next cycle state IDLE, product=0, busy=0, done never pulses. A subsequent 9×9 → product=81.
- Simultaneous reset and start in IDLE → stays IDLE, busy=0; all outputs at their reset values.

Source files
------------

// File: rtl/mul_sequencer.sv
// Shift-and-add 32-bit multiplier sequencer that borrows the shared ALU.
// It issues one ALU operation per clock: ADD, SLL, SRL repeated until the multiplier runs out of set bits.
module mul_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result
);

    localparam logic [3:0] OpAdd = 4'b0011;
    localparam logic [3:0] OpSll = 4'b0100;
    localparam logic [3:0] OpSrl = 4'b0110;

    typedef enum logic [2:0] {
        StIdle,
        StAdd,
        StShl,
        StShr,
        StDone
    } state_e;

    state_e      state_q;
    logic [31:0] acc_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] product_q;
    logic [5:0]  iter_q;
    logic [5:0]  iter_d;

    // The counter can never legitimately pass 32, but it is clamped so it stays bounded.
    assign iter_d = (iter_q == 6'd32) ? iter_q : iter_q + 6'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            acc_q     <= 32'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            iter_q    <= 6'd0;
            product_q <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q    <= 32'd0;
                        mcand_q  <= a;
                        mplier_q <= b;
                        iter_q   <= 6'd0;
                        state_q  <= StAdd;
                    end
                end
                StAdd: begin
                    acc_q   <= alu_result;
                    state_q <= StShl;
                end
                StShl: begin
                    mcand_q <= alu_result;
                    state_q <= StShr;
                end
                StShr: begin
                    mplier_q <= alu_result;
                    iter_q   <= iter_d;
                    // Once the shifted multiplier is zero, acc already holds the full product.
                    if (alu_result == 32'd0) begin
                        product_q <= acc_q;
                        state_q   <= StDone;
                    end else begin
                        state_q <= StAdd;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        alu_op = OpAdd;
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        case (state_q)
            StAdd: begin
                alu_op = OpAdd;
                alu_a  = acc_q;
                alu_b  = mplier_q[0] ? mcand_q : 32'd0;
            end
            StShl: begin
                alu_op = OpSll;
                alu_a  = mcand_q;
                alu_b  = 32'd1;
            end
            StShr: begin
                alu_op = OpSrl;
                alu_a  = mplier_q;
                alu_b  = 32'd1;
            end
            default: begin
                alu_op = OpAdd;
                alu_a  = 32'd0;
                alu_b  = 32'd0;
            end
        endcase
    end

    assign busy    = (state_q == StAdd) || (state_q == StShl) || (state_q == StShr);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: a behavioural ALU plus a reference model built on plain a*b
// arithmetic and the highest set bit of b, with directed boundary scenarios and randomized operands.
module tb_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    int checks = 0;
    int errors = 0;

    mul_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the shared ALU.
    always_comb begin
        case (alu_op)
            4'b0011: alu_result = alu_a + alu_b;
            4'b0100: alu_result = alu_a << alu_b[4:0];
            4'b0110: alu_result = alu_a >> alu_b[4:0];
            default: alu_result = 32'd0;
        endcase
    end

    function automatic int ref_iters(input logic [31:0] bv);
        int n = 1;
        for (int i = 0; i < 32; i++) begin
            if (bv[i]) n = i + 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] ref_product(input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] full;
        full = {32'd0, av} * {32'd0, bv};
        return full[31:0];
    endfunction

    function automatic logic [3:0] ref_op(input int cycle);
        case (cycle % 3)
            0:       return 4'b0011;
            1:       return 4'b0100;
            default: return 4'b0110;
        endcase
    endfunction

    // Runs one full multiplication from IDLE and checks latency, ALU op sequence, done pulse and product.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input string name);
        int          n;
        int          cycles;
        logic [31:0] expProd;
        bit          seqOk;
        logic [3:0]  badOp;
        n       = ref_iters(bv);
        expProd = ref_product(av, bv);
        seqOk   = 1'b1;
        badOp   = 4'd0;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cycles = 0;
        while (!done && cycles < 200) begin
            if (seqOk && (busy !== 1'b1 || alu_op !== ref_op(cycles))) begin
                seqOk = 1'b0;
                badOp = alu_op;
            end
            cycles++;
            @(negedge clk);
        end
        checks++;
        if (!seqOk) begin
            errors++;
            $display("[TB] FAIL %s op_sequence: got op %b (busy %b) where the ADD/SLL/SRL sequence was required", name, badOp, busy);
        end
        checks++;
        if (cycles !== 3 * n) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d busy cycles, expected %0d", name, cycles, 3 * n);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== expProd) begin
            errors++;
            $display("[TB] FAIL %s done_cycle: done=%b busy=%b product=%h, expected done=1 busy=0 product=%h", name, done, busy, product, expProd);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== expProd) begin
            errors++;
            $display("[TB] FAIL %s after_done: done=%b busy=%b product=%h, expected done=0 busy=0 product=%h", name, done, busy, product, expProd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 ||
            alu_op !== 4'b0011 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: busy=%b done=%b product=%h op=%b a=%h b=%h", busy, done, product, alu_op, alu_a, alu_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_op(32'd3, 32'd5, "mul_3x5");
        checks++;
        if (product !== 32'd15) begin
            errors++;
            $display("[TB] FAIL mul_3x5_const: got %0d, expected 15", product);
        end
    endtask

    task automatic test_b_zero();
        int cycles;
        @(negedge clk);
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || alu_op !== 4'b0011 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            errors++;
            $display("[TB] FAIL b_zero_first_add: busy=%b op=%b a=%h b=%h, expected 1 0011 0 0", busy, alu_op, alu_a, alu_b);
        end
        cycles = 0;
        while (!done && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        checks++;
        if (cycles !== 3 || product !== 32'd0) begin
            errors++;
            $display("[TB] FAIL b_zero_result: cycles=%0d product=%h, expected 3 and 0", cycles, product);
        end
        @(negedge clk);
    endtask

    task automatic test_max();
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        checks++;
        if (product !== 32'h0000_0001) begin
            errors++;
            $display("[TB] FAIL mul_max_const: got %h, expected 00000001", product);
        end
        run_op(32'd0, 32'h8000_1234, "a_zero");
    endtask

    task automatic test_random();
        logic [31:0] av;
        logic [31:0] bv;
        for (int i = 0; i < 20; i++) begin
            av = $urandom;
            bv = $urandom;
            bv = bv >> $urandom_range(0, 31);
            if (i % 7 == 3) bv = 32'd0;
            run_op(av, bv, "random");
        end
    endtask

    task automatic test_ignored_start();
        int cycles;
        @(negedge clk);
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        cycles = 0;
        while (!done && cycles < 200) begin
            if (cycles == 1) begin
                start = 1'b1;
                a     = 32'h0000_0011;
                b     = 32'h0000_0011;
            end else begin
                start = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        checks++;
        if (cycles !== 9 || product !== 32'd15) begin
            errors++;
            $display("[TB] FAIL ignored_start: cycles=%0d product=%0d, expected 9 and 15", cycles, product);
        end
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd15) begin
            errors++;
            $display("[TB] FAIL start_in_done: busy=%b done=%b product=%0d, expected 0 0 15", busy, done, product);
        end
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        checks++;
        if (cycles !== 6 || product !== 32'd4) begin
            errors++;
            $display("[TB] FAIL back_to_back: cycles=%0d product=%0d, expected 6 and 4", cycles, product);
        end
        @(negedge clk);
    endtask

    task automatic test_held_start();
        int cycles;
        @(negedge clk);
        start = 1'b1;
        a     = 32'd6;
        b     = 32'd3;
        @(negedge clk);
        cycles = 0;
        while (!done && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        checks++;
        if (cycles !== 6 || product !== 32'd18) begin
            errors++;
            $display("[TB] FAIL held_start_first: cycles=%0d product=%0d, expected 6 and 18", cycles, product);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_start_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_start_reaccept: busy=%b, expected 1", busy);
        end
        cycles = 0;
        while (!done && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || product !== 32'd18) begin
            errors++;
            $display("[TB] FAIL held_start_second: done=%b product=%0d, expected 1 and 18", done, product);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit sawActivity;
        @(negedge clk);
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 || alu_op !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL mid_reset: busy=%b done=%b product=%h op=%b, expected 0 0 0 0011", busy, done, product, alu_op);
        end
        sawActivity = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) sawActivity = 1'b1;
        end
        checks++;
        if (sawActivity) begin
            errors++;
            $display("[TB] FAIL mid_reset_quiet: got busy/done activity after reset, expected none");
        end
        run_op(32'd9, 32'd9, "mul_9x9");
        checks++;
        if (product !== 32'd81) begin
            errors++;
            $display("[TB] FAIL mul_9x9_const: got %0d, expected 81", product);
        end
    endtask

    task automatic test_reset_start();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 ||
            alu_op !== 4'b0011 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_and_start: busy=%b done=%b product=%h op=%b a=%h b=%h", busy, done, product, alu_op, alu_a, alu_b);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_and_start_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_b_zero();
        test_max();
        test_random();
        test_ignored_start();
        test_held_start();
        test_mid_reset();
        test_reset_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
